// File: rtl/pending_request_scheduler.sv
// Sticky pending-request capture with lowest-index-first grant over a valid/ready offer.
// Also counts request pulses that land on an already-pending, not-being-cleared bit.
module pending_request_scheduler #(
    parameter int WIDTH      = 5,
    parameter int ADDR_WIDTH = $clog2(WIDTH),
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      req_in,
    input  logic [WIDTH-1:0]      mask_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [WIDTH-1:0]      pending,
    output logic [CNT_WIDTH-1:0]  coalesce_cnt,
    output logic                  busy
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      pending_q, pending_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  hs;
    logic [WIDTH-1:0]      clr;
    logic [WIDTH-1:0]      elig;
    logic [WIDTH-1:0]      coal;
    logic                  any_elig;
    logic [ADDR_WIDTH-1:0] sel_idx;
    logic [CNT_WIDTH:0]    inc;
    logic [CNT_WIDTH:0]    sum;

    assign hs   = (state_q == OFFER) && out_ready;
    assign elig = pending_q & ~mask_in;

    always_comb begin
        clr = '0;
        for (int i = 0; i < WIDTH; i++)
            clr[i] = hs && (out_addr_q == ADDR_WIDTH'(i));
    end

    // Re-arm wins over clear; coalescing excludes bits being cleared this edge.
    assign pending_d = (pending_q & ~clr) | req_in;
    assign coal      = req_in & pending_q & ~clr;

    always_comb begin
        any_elig = 1'b0;
        sel_idx  = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (elig[i]) begin
                any_elig = 1'b1;
                sel_idx  = ADDR_WIDTH'(i);
            end
        end
    end

    always_comb begin
        inc = '0;
        for (int i = 0; i < WIDTH; i++)
            inc = inc + (CNT_WIDTH+1)'(coal[i]);
        sum   = {1'b0, cnt_q} + inc;
        cnt_d = sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    end

    always_comb begin
        state_d    = state_q;
        out_addr_d = out_addr_q;
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    state_d    = OFFER;
                    out_addr_d = sel_idx;
                end
            end
            OFFER: begin
                // Offer is frozen until taken; new requests or mask changes don't touch it.
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            out_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            out_addr_q <= out_addr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid    = (state_q == OFFER);
    assign out_addr     = out_addr_q;
    assign pending      = pending_q;
    assign coalesce_cnt = cnt_q;
    assign busy         = (|pending_q) || out_valid;

endmodule

// File: tb/tb_pending_request_scheduler.sv
// Directed bench for pending_request_scheduler: grant order, hold-on-offer, re-arm,
// masking, coalesce saturation and asynchronous reset.
module tb_pending_request_scheduler;

    localparam int W  = 5;
    localparam int AW = $clog2(W);
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  req_in;
    logic [W-1:0]  mask_in;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [W-1:0]  pending;
    logic [CW-1:0] coalesce_cnt;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    pending_request_scheduler #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_in       (req_in),
        .mask_in      (mask_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .pending      (pending),
        .coalesce_cnt (coalesce_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_in = '0; mask_in = '0; out_ready = 1'b0;
        #12;
        chk("rst_pending", pending, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_cnt", coalesce_cnt, 0);
        chk("rst_busy", busy, 0);
        tick();
        rst = 1'b0;

        // single pulse on bit 2
        out_ready = 1'b1;
        req_in = 5'b00100; tick(); req_in = '0;
        chk("s_pend", pending, 5'b00100);
        chk("s_valid_e", out_valid, 0);
        tick();
        chk("s_valid", out_valid, 1);
        chk("s_addr", out_addr, 2);
        tick();
        chk("s_pend_clr", pending, 0);
        chk("s_valid_clr", out_valid, 0);
        chk("s_busy", busy, 0);

        // priority order 1,2,4 with idle gaps
        req_in = 5'b10110; tick(); req_in = '0;
        chk("p_pend", pending, 5'b10110);
        tick(); chk("p_v1", out_valid, 1); chk("p_a1", out_addr, 1);
        tick(); chk("p_gap1", out_valid, 0); chk("p_pend1", pending, 5'b10100);
        tick(); chk("p_v2", out_valid, 1); chk("p_a2", out_addr, 2);
        tick(); chk("p_gap2", out_valid, 0); chk("p_pend2", pending, 5'b10000);
        tick(); chk("p_v3", out_valid, 1); chk("p_a3", out_addr, 4); chk("p_busy3", busy, 1);
        tick(); chk("p_end", out_valid, 0); chk("p_busy_end", busy, 0);
        chk("p_addr_hold", out_addr, 4);

        // offer on 3 held while bit 0 arrives
        out_ready = 1'b0;
        req_in = 5'b01000; tick(); req_in = '0;
        tick(); chk("h_v", out_valid, 1); chk("h_a", out_addr, 3);
        req_in = 5'b00001; tick(); req_in = '0;
        chk("h_a_hold", out_addr, 3); chk("h_pend", pending, 5'b01001);
        tick(); chk("h_a_hold2", out_addr, 3); chk("h_v_hold", out_valid, 1);
        out_ready = 1'b1;
        tick(); chk("h_hs", out_valid, 0); chk("h_pend_hs", pending, 5'b00001);
        tick(); chk("h_next_v", out_valid, 1); chk("h_next_a", out_addr, 0);
        tick(); chk("h_done", pending, 0);
        chk("h_cnt", coalesce_cnt, 0);

        // coalescing and re-arm on bit 2
        out_ready = 1'b0;
        req_in = 5'b00100; tick();
        chk("c_cnt0", coalesce_cnt, 0);
        tick(); chk("c_cnt1", coalesce_cnt, 1);
        tick(); chk("c_cnt2", coalesce_cnt, 2);
        req_in = '0;
        chk("c_v", out_valid, 1); chk("c_a", out_addr, 2);
        req_in = 5'b00100; out_ready = 1'b1; tick(); req_in = '0;
        chk("r_pend", pending, 5'b00100);
        chk("r_cnt", coalesce_cnt, 2);
        chk("r_v", out_valid, 0);
        tick(); chk("r_reoffer_v", out_valid, 1); chk("r_reoffer_a", out_addr, 2);
        tick(); chk("r_clr", pending, 0);

        // all masked
        mask_in = 5'b11111;
        req_in = 5'b01010; tick(); req_in = '0;
        tick(); tick();
        chk("m_v", out_valid, 0); chk("m_busy", busy, 1); chk("m_pend", pending, 5'b01010);
        mask_in = 5'b10111;
        tick(); chk("m_v3", out_valid, 1); chk("m_a3", out_addr, 3);
        tick(); chk("m_pend3", pending, 5'b00010);
        tick(); chk("m_still_masked", out_valid, 0);
        mask_in = '0;
        tick(); chk("m_v1", out_valid, 1); chk("m_a1", out_addr, 1);
        tick(); chk("m_empty", pending, 0);

        // saturation: counter at 2, bit 0 held pending under an unaccepted offer
        out_ready = 1'b0;
        req_in = 5'b00001; tick();
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 251) chk("sat_254", coalesce_cnt, 254);
        end
        req_in = '0;
        chk("sat_255", coalesce_cnt, 255);

        // async reset mid-offer
        chk("pre_rst_v", out_valid, 1);
        #2 rst = 1'b1; #1;
        chk("ar_pending", pending, 0);
        chk("ar_valid", out_valid, 0);
        chk("ar_addr", out_addr, 0);
        chk("ar_cnt", coalesce_cnt, 0);
        chk("ar_busy", busy, 0);
        tick(); rst = 1'b0;
        tick(); chk("post_rst_v", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pending_request_scheduler.md
Name: pending_request_scheduler

Overview:
- Sequential stage that sits directly upstream-facing around the binary priority encoder.
- Captures single-cycle request pulses from WIDTH sources into a sticky pending register.
- Uses lowest-index-first priority selection over the unmasked pending bits, and presents one source address at a time on a valid/ready handshake.
- Clears each served bit on acceptance and counts request pulses that coalesce into an already-pending bit.

Parameters:
- WIDTH, 5, number of request sources (>= 2).
- ADDR_WIDTH, $clog2(WIDTH), width of the granted source address.
- CNT_WIDTH, 8, width of the saturating coalesce counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- req_in  input  WIDTH  request pulses, one bit per source, sampled each rising edge.
- mask_in  input  WIDTH  1 = source not eligible for selection; its pending bit is still kept.
- out_valid  output  1  out_addr holds a pending, selected source.
- out_ready  input  1  consumer accepts out_addr when high together with out_valid.
- out_addr  output  ADDR_WIDTH  index of the offered source.
- pending  output  WIDTH  current sticky pending register.
- coalesce_cnt  output  CNT_WIDTH  saturating count of coalesced request pulses.
- busy  output  1  high whenever pending != 0 or out_valid.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- Reset (asynchronous assert, any time including mid-offer): pending=0, out_valid=0, out_addr=0, coalesce_cnt=0, FSM=IDLE. Release is taken at the next rising edge.
- All outputs are registered except busy, which is a combinational OR of the registers.
- Pending update each edge, per bit i: next = (pending[i] & ~clr[i]) | req_in[i].
  - clr[i] is 1 only for the bit at out_addr on a handshake edge.
  - Simultaneous clear and new request on the same bit leaves the bit set (re-arm).
- Selection: lowest index i with pending[i] & ~mask_in[i], evaluated on the registered pending value. Bit 0 has the highest priority.
- FSM states:
  - IDLE: if any eligible bit exists, latch its index into out_addr, set out_valid=1, go to OFFER. Otherwise stay in IDLE with out_valid=0.
  - OFFER: out_valid=1 and out_addr are held stable until the handshake. A new lower-index request or a mask_in change does not alter or withdraw the offer. On out_valid&out_ready: clear pending[out_addr] (subject to re-arm), drop out_valid, return to IDLE.
- Latency: a req_in pulse sampled at edge E gives out_valid high after edge E+1 at the earliest.
- Throughput: at most one grant per 2 cycles, because of the mandatory IDLE cycle after each handshake.
- out_ready while out_valid=0 is ignored.
- Coalescing: on each edge, add the count of bits with req_in[i]=1 and pending[i]=1 and clr[i]=0. The counter saturates at 2^CNT_WIDTH-1. Re-arm events are not counted.
- All mask bits set with pending nonzero: FSM stays in IDLE, out_valid=0, busy=1.
- out_addr retains its last granted value while out_valid=0.

Test Plan:
- Reset with req_in=0 -> pending=0, out_valid=0, out_addr=0, coalesce_cnt=0, busy=0. Assert rst mid-OFFER -> all outputs return to these values immediately, without waiting for a clock edge.
- WIDTH=5, single pulse req_in=5'b00100 at edge E, out_ready=1 -> out_valid high after E+1 with out_addr=2; after the handshake edge, pending=0 and out_valid=0.
- Pulse req_in=5'b10110, out_ready=1 -> grants in order 1, 2, 4, each out_valid pulse separated by one idle cycle; busy falls after the last grant.
- Offer active on addr 3 with out_ready=0, then pulse bit 0 -> out_addr stays 3 until out_ready=1. The next grant is 0.
- Pulse bit 2 three times while it is pending -> coalesce_cnt=2. Pulse bit 2 on the same edge as its handshake -> bit stays set, coalesce_cnt unchanged, bit 2 is re-offered.
- mask_in=5'b11111 with pending=5'b01010 -> out_valid stays 0, busy=1. Clear mask_in[3] -> out_addr=3 offered. Drive 300 coalescing pulses with CNT_WIDTH=8 -> coalesce_cnt saturates at 255.
